// File: rtl/sdram_ctrl_burst.sv
// Single-port SDRAM controller: per-bank open-row tracking, auto-refresh,
// multi-beat read bursts through a CAS-latency pipeline, and byte-masked writes.
module sdram_ctrl_burst #(
    parameter int DW     = 32,
    parameter int COL_W  = 8,
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int T_RCD  = 3,
    parameter int T_RP   = 3,
    parameter int T_RFC  = 7,
    parameter int T_CAS  = 3,
    parameter int T_REFI = 750,
    parameter int BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_rw,
    input  logic [ROW_W+BANK_W+COL_W-1:0]   req_addr,
    input  logic [DW-1:0]                   req_wdata,
    input  logic [DW/8-1:0]                 req_be,
    output logic                            rsp_valid,
    output logic [DW-1:0]                   rsp_data,
    output logic [ROW_W+BANK_W+COL_W-1:0]   rsp_addr,
    output logic                            sdram_cke,
    output logic                            sdram_cs,
    output logic                            sdram_ras,
    output logic                            sdram_cas,
    output logic                            sdram_we,
    output logic [BANK_W-1:0]               sdram_ba,
    output logic [ROW_W-1:0]                sdram_a,
    output logic [DW/8-1:0]                 sdram_dqm,
    input  logic [DW-1:0]                   sdram_dqi,
    output logic [DW-1:0]                   sdram_dqo,
    output logic                            sdram_dq_oe
);
    localparam int AW  = ROW_W + BANK_W + COL_W;
    localparam int NB  = 1 << BANK_W;
    localparam int BEW = DW / 8;
    localparam int RCW = $clog2(T_REFI + 1);

    // Wait loads: the next command state becomes current after this many cycles.
    localparam logic [15:0] W_RP  = 16'(T_RP - 1);
    localparam logic [15:0] W_RCD = 16'(T_RCD - 1);
    localparam logic [15:0] W_RFC = 16'(T_RFC);

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    typedef enum logic [3:0] {
        StInit, StIdle, StPre, StPreAll, StAct, StRd, StWr, StRef, StWait
    } state_t;

    state_t              r_state;
    state_t              r_next;
    logic [15:0]         r_wait;
    logic [ROW_W-1:0]    r_row;
    logic [BANK_W-1:0]   r_bank;
    logic [COL_W-1:0]    r_col;
    logic                r_rw;
    logic [DW-1:0]       r_wdata;
    logic [BEW-1:0]      r_be;
    logic [COL_W-1:0]    r_beat;
    logic [NB-1:0]       r_bank_open;
    logic [ROW_W-1:0]    r_open_row [NB];
    logic [RCW-1:0]      r_ref_cnt;
    logic                r_ref_pend;

    logic                r_cke;
    logic [3:0]          r_cmd;
    logic [BANK_W-1:0]   r_ba;
    logic [ROW_W-1:0]    r_a;
    logic [BEW-1:0]      r_dqm;
    logic [DW-1:0]       r_dqo;
    logic                r_dq_oe;
    logic [AW-1:0]       r_rd_addr;

    logic [T_CAS-1:0]    r_pv;
    logic [AW-1:0]       r_pa [T_CAS];
    logic                r_rsp_valid;
    logic [DW-1:0]       r_rsp_data;
    logic [AW-1:0]       r_rsp_addr;

    logic [ROW_W-1:0]    w_req_row;
    logic [BANK_W-1:0]   w_req_bank;
    logic [COL_W-1:0]    w_req_col;
    logic [COL_W-1:0]    w_rd_col;
    logic                w_pipe_empty;
    logic                w_ready;

    assign w_req_row    = req_addr[AW-1 -: ROW_W];
    assign w_req_bank   = req_addr[COL_W +: BANK_W];
    assign w_req_col    = req_addr[COL_W-1:0];
    assign w_rd_col     = r_col + r_beat;
    // A READ still on the pins has not yet entered the shift register.
    assign w_pipe_empty = !(|r_pv) && (r_cmd != CMD_READ);
    assign w_ready      = !rst && (r_state == StIdle) && !r_ref_pend && w_pipe_empty;

    assign req_ready   = w_ready;
    assign sdram_cke   = r_cke;
    assign sdram_cs    = r_cmd[3];
    assign sdram_ras   = r_cmd[2];
    assign sdram_cas   = r_cmd[1];
    assign sdram_we    = r_cmd[0];
    assign sdram_ba    = r_ba;
    assign sdram_a     = r_a;
    assign sdram_dqm   = r_dqm;
    assign sdram_dqo   = r_dqo;
    assign sdram_dq_oe = r_dq_oe;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_addr    = r_rsp_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StInit;
            r_cke       <= 1'b0;
            r_cmd       <= CMD_NOP;
            r_ba        <= '0;
            r_a         <= '0;
            r_dqm       <= '0;
            r_dqo       <= '0;
            r_dq_oe     <= 1'b0;
            r_bank_open <= '0;
            r_ref_cnt   <= '0;
            r_ref_pend  <= 1'b0;
        end else begin
            r_cke   <= 1'b1;
            r_cmd   <= CMD_NOP;
            r_dq_oe <= 1'b0;
            r_dqm   <= '0;
            unique case (r_state)
                StInit: r_state <= StIdle;
                StIdle: begin
                    if (r_ref_pend && w_pipe_empty) begin
                        r_state <= StPreAll;
                    end else if (req_valid && w_ready) begin
                        r_row   <= w_req_row;
                        r_bank  <= w_req_bank;
                        r_col   <= w_req_col;
                        r_rw    <= req_rw;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_beat  <= '0;
                        if (!r_bank_open[w_req_bank]) begin
                            r_state <= StAct;
                        end else if (r_open_row[w_req_bank] == w_req_row) begin
                            r_state <= req_rw ? StWr : StRd;
                        end else begin
                            r_state <= StPre;
                        end
                    end
                end
                StPre: begin
                    r_cmd               <= CMD_PRE;
                    r_ba                <= r_bank;
                    r_a                 <= '0;
                    r_bank_open[r_bank] <= 1'b0;
                    if (W_RP != 16'd0) begin
                        r_wait  <= W_RP;
                        r_next  <= StAct;
                        r_state <= StWait;
                    end else begin
                        r_state <= StAct;
                    end
                end
                StPreAll: begin
                    r_cmd       <= CMD_PRE;
                    r_a         <= '0;
                    r_a[10]     <= 1'b1;
                    r_bank_open <= '0;
                    if (W_RP != 16'd0) begin
                        r_wait  <= W_RP;
                        r_next  <= StRef;
                        r_state <= StWait;
                    end else begin
                        r_state <= StRef;
                    end
                end
                StAct: begin
                    r_cmd               <= CMD_ACT;
                    r_ba                <= r_bank;
                    r_a                 <= r_row;
                    r_bank_open[r_bank] <= 1'b1;
                    r_open_row[r_bank]  <= r_row;
                    if (W_RCD != 16'd0) begin
                        r_wait  <= W_RCD;
                        r_next  <= r_rw ? StWr : StRd;
                        r_state <= StWait;
                    end else begin
                        r_state <= r_rw ? StWr : StRd;
                    end
                end
                StWr: begin
                    r_cmd   <= CMD_WRITE;
                    r_ba    <= r_bank;
                    r_a     <= ROW_W'(r_col);
                    r_dqo   <= r_wdata;
                    r_dq_oe <= 1'b1;
                    r_dqm   <= ~r_be;
                    r_state <= StIdle;
                end
                StRd: begin
                    r_cmd     <= CMD_READ;
                    r_ba      <= r_bank;
                    r_a       <= ROW_W'(w_rd_col);
                    r_rd_addr <= {r_row, r_bank, w_rd_col};
                    r_beat    <= r_beat + COL_W'(1);
                    if (r_beat == COL_W'(BURST - 1)) begin
                        r_state <= StIdle;
                    end
                end
                StRef: begin
                    r_cmd      <= CMD_REF;
                    r_ref_pend <= 1'b0;
                    r_wait     <= W_RFC;
                    r_next     <= StIdle;
                    r_state    <= StWait;
                end
                StWait: begin
                    if (r_wait <= 16'd1) begin
                        r_state <= r_next;
                    end else begin
                        r_wait <= r_wait - 16'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Placed after the case so a wrap coinciding with REF re-arms refresh.
            if (r_ref_cnt == RCW'(T_REFI - 1)) begin
                r_ref_cnt  <= '0;
                r_ref_pend <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + RCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
        end else begin
            r_pv[0] <= (r_cmd == CMD_READ);
            r_pa[0] <= r_rd_addr;
            for (int i = 1; i < T_CAS; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
            r_rsp_valid <= r_pv[T_CAS-1];
            if (r_pv[T_CAS-1]) begin
                r_rsp_data <= sdram_dqi;
                r_rsp_addr <= r_pa[T_CAS-1];
            end
        end
    end

endmodule

// File: tb/tb_sdram_ctrl_burst.sv
// Directed bench for sdram_ctrl_burst: logs pin commands and responses per cycle,
// then checks each scenario's sequence, timing and data against hand-derived values.
module tb_sdram_ctrl_burst;
    localparam int AW = 23;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_rw = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          sdram_cke, sdram_cs, sdram_ras, sdram_cas, sdram_we;
    logic [1:0]    sdram_ba;
    logic [12:0]   sdram_a;
    logic [3:0]    sdram_dqm;
    logic [31:0]   sdram_dqi;
    logic [31:0]   sdram_dqo;
    logic          sdram_dq_oe;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int viol = 0;

    typedef struct {
        int          t;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic        oe;
        logic [31:0] dqo;
        logic [3:0]  dqm;
    } cmd_t;
    typedef struct {
        int          t;
        logic [22:0] addr;
        logic [31:0] data;
    } rsp_t;
    cmd_t cq[$];
    rsp_t rq[$];
    logic       prev_wr = 1'b0;
    logic       post_oe = 1'b1;
    logic [3:0] post_dqm = 4'hF;
    logic [3:0] w_cmd;

    sdram_ctrl_burst dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .sdram_cke(sdram_cke), .sdram_cs(sdram_cs), .sdram_ras(sdram_ras),
        .sdram_cas(sdram_cas), .sdram_we(sdram_we), .sdram_ba(sdram_ba),
        .sdram_a(sdram_a), .sdram_dqm(sdram_dqm), .sdram_dqi(sdram_dqi),
        .sdram_dqo(sdram_dqo), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data stamps the cycle it is presented in, exposing the sampling point.
    assign sdram_dqi = {16'hC0DE, cyc[15:0]};
    assign w_cmd = {sdram_cs, sdram_ras, sdram_cas, sdram_we};

    always @(negedge clk) begin
        if (w_cmd != C_NOP)
            cq.push_back('{cyc, w_cmd, sdram_ba, sdram_a, sdram_dq_oe, sdram_dqo, sdram_dqm});
        if (rsp_valid) rq.push_back('{cyc, rsp_addr, rsp_data});
        if (w_cmd != C_WR && (sdram_dq_oe || sdram_dqm != 4'h0)) viol++;
        if (prev_wr) begin
            post_oe  = sdram_dq_oe;
            post_dqm = sdram_dqm;
        end
        prev_wr = (w_cmd == C_WR);
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [22:0] mk(input logic [12:0] row, input logic [1:0] bank,
                                       input logic [7:0] col);
        return {row, bank, col};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic rw, input logic [12:0] row, input logic [1:0] bank,
                          input logic [7:0] col, input logic [31:0] wd, input logic [3:0] be,
                          output int rdy_t);
        req_rw    = rw;
        req_addr  = mk(row, bank, col);
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        rdy_t     = -1;
        for (int i = 0; i < 2000; i++) begin
            if (req_ready) begin
                rdy_t = cyc;
                break;
            end
            tick();
        end
        chk("req_accepted", 64'(rdy_t >= 0), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic settle();
        int ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("idle_reached", 64'(ok), 64'd1);
        repeat (3) tick();
    endtask

    task automatic chk_burst(input string tag, input int base, input logic [12:0] row,
                             input logic [1:0] bank, input logic [7:0] col0);
        logic [7:0] c;
        chk({tag, "_rsp_cnt"}, 64'(rq.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            c = col0 + 8'(k);
            chk($sformatf("%s_cmd%0d", tag, k), 64'(cq[base+k].cmd), 64'(C_RD));
            chk($sformatf("%s_ba%0d", tag, k), 64'(cq[base+k].ba), 64'(bank));
            chk($sformatf("%s_col%0d", tag, k), 64'(cq[base+k].a), 64'(c));
            chk($sformatf("%s_t%0d", tag, k), 64'(cq[base+k].t), 64'(cq[base].t + k));
            chk($sformatf("%s_rsp_t%0d", tag, k), 64'(rq[k].t), 64'(cq[base+k].t + 4));
            chk($sformatf("%s_rsp_addr%0d", tag, k), 64'(rq[k].addr), 64'(mk(row, bank, c)));
            chk($sformatf("%s_rsp_data%0d", tag, k), 64'(rq[k].data),
                64'({16'hC0DE, 16'(cq[base+k].t + 3)}));
        end
    endtask

    initial begin
        int rdy;
        int drop_t;
        int nrd;

        // Reset state
        repeat (3) tick();
        chk("rst_cke", 64'(sdram_cke), 64'd0);
        chk("rst_cmd", 64'(w_cmd), 64'(C_NOP));
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_oe_dqm_a_ba", 64'({sdram_dq_oe, sdram_dqm, sdram_a, sdram_ba}), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        chk("post_rst_cke", 64'(sdram_cke), 64'd1);

        // Read, closed bank
        cq.delete(); rq.delete();
        do_req(1'b0, 13'd5, 2'd1, 8'd8, 32'h0, 4'h0, rdy);
        settle();
        chk("rd1_ncmd", 64'(cq.size()), 64'd5);
        chk("rd1_act", 64'(cq[0].cmd), 64'(C_ACT));
        chk("rd1_act_t", 64'(cq[0].t), 64'(rdy + 2));
        chk("rd1_act_ba_a", 64'({cq[0].ba, cq[0].a}), 64'({2'd1, 13'd5}));
        chk("rd1_trcd", 64'(cq[1].t), 64'(cq[0].t + 3));
        chk_burst("rd1", 1, 13'd5, 2'd1, 8'd8);

        // Row hit
        cq.delete(); rq.delete();
        do_req(1'b0, 13'd5, 2'd1, 8'd0, 32'h0, 4'h0, rdy);
        settle();
        chk("hit_ncmd", 64'(cq.size()), 64'd4);
        chk("hit_rd_t", 64'(cq[0].t), 64'(rdy + 2));
        chk_burst("hit", 0, 13'd5, 2'd1, 8'd0);

        // Row conflict
        cq.delete(); rq.delete();
        do_req(1'b0, 13'd9, 2'd1, 8'd0, 32'h0, 4'h0, rdy);
        settle();
        chk("cf_ncmd", 64'(cq.size()), 64'd6);
        chk("cf_pre", 64'(cq[0].cmd), 64'(C_PRE));
        chk("cf_pre_ba_a", 64'({cq[0].ba, cq[0].a}), 64'({2'd1, 13'd0}));
        chk("cf_act", 64'(cq[1].cmd), 64'(C_ACT));
        chk("cf_act_a", 64'(cq[1].a), 64'd9);
        chk("cf_trp", 64'(cq[1].t), 64'(cq[0].t + 3));
        chk("cf_trcd", 64'(cq[2].t), 64'(cq[1].t + 3));
        chk_burst("cf", 2, 13'd9, 2'd1, 8'd0);

        // Byte-masked write (row hit)
        cq.delete(); rq.delete();
        do_req(1'b1, 13'd9, 2'd1, 8'd7, 32'hA5A5_1234, 4'b0101, rdy);
        settle();
        chk("wr_ncmd", 64'(cq.size()), 64'd1);
        chk("wr_cmd", 64'(cq[0].cmd), 64'(C_WR));
        chk("wr_t", 64'(cq[0].t), 64'(rdy + 2));
        chk("wr_ba_a", 64'({cq[0].ba, cq[0].a}), 64'({2'd1, 13'd7}));
        chk("wr_oe", 64'(cq[0].oe), 64'd1);
        chk("wr_dqo", 64'(cq[0].dqo), 64'h0000_0000_A5A5_1234);
        chk("wr_dqm", 64'(cq[0].dqm), 64'b1010);
        chk("wr_next_oe", 64'(post_oe), 64'd0);
        chk("wr_next_dqm", 64'(post_dqm), 64'd0);
        chk("wr_no_rsp", 64'(rq.size()), 64'd0);

        // Column wrap
        cq.delete(); rq.delete();
        do_req(1'b0, 13'd9, 2'd1, 8'd254, 32'h0, 4'h0, rdy);
        settle();
        chk("wrap_ncmd", 64'(cq.size()), 64'd4);
        chk_burst("wrap", 0, 13'd9, 2'd1, 8'd254);

        // Refresh priority: ready drops when ref_pend sets while idle
        cq.delete(); rq.delete();
        drop_t = -1;
        for (int i = 0; i < 1000; i++) begin
            if (!req_ready) begin
                drop_t = cyc;
                break;
            end
            tick();
        end
        chk("ref_ready_drop", 64'(drop_t >= 0), 64'd1);
        do_req(1'b0, 13'd3, 2'd2, 8'd4, 32'h0, 4'h0, rdy);
        settle();
        chk("ref_ncmd", 64'(cq.size()), 64'd7);
        chk("ref_preall", 64'(cq[0].cmd), 64'(C_PRE));
        chk("ref_preall_a", 64'(cq[0].a), 64'h400);
        chk("ref_preall_t", 64'(cq[0].t), 64'(drop_t + 2));
        chk("ref_cmd", 64'(cq[1].cmd), 64'(C_REF));
        chk("ref_trp", 64'(cq[1].t), 64'(cq[0].t + 3));
        chk("ref_trfc_ready", 64'(rdy), 64'(cq[1].t + 7));
        chk("ref_act", 64'(cq[2].cmd), 64'(C_ACT));
        chk("ref_act_ba_a", 64'({cq[2].ba, cq[2].a}), 64'({2'd2, 13'd3}));
        chk("ref_act_t", 64'(cq[2].t), 64'(rdy + 2));
        chk_burst("refrd", 3, 13'd3, 2'd2, 8'd4);

        // Reset mid-burst (bank 2 row 3 open, so this is a hit)
        cq.delete(); rq.delete();
        do_req(1'b0, 13'd3, 2'd2, 8'd20, 32'h0, 4'h0, rdy);
        nrd = 0;
        for (int i = 0; i < 50; i++) begin
            if (w_cmd == C_RD) nrd++;
            if (nrd == 2) break;
            tick();
        end
        chk("mid_two_reads", 64'(nrd), 64'd2);
        tick();
        rst = 1'b1;
        rq.delete();
        repeat (2) tick();
        chk("mid_rst_cke", 64'(sdram_cke), 64'd0);
        chk("mid_rst_cmd", 64'(w_cmd), 64'(C_NOP));
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("mid_post_ready", 64'(req_ready), 64'd1);
        repeat (20) tick();
        chk("mid_no_rsp", 64'(rq.size()), 64'd0);
        cq.delete(); rq.delete();
        do_req(1'b0, 13'd3, 2'd2, 8'd20, 32'h0, 4'h0, rdy);
        settle();
        chk("mid_ncmd", 64'(cq.size()), 64'd5);
        chk("mid_act", 64'(cq[0].cmd), 64'(C_ACT));
        chk("mid_act_ba_a", 64'({cq[0].ba, cq[0].a}), 64'({2'd2, 13'd3}));
        chk_burst("mid", 1, 13'd3, 2'd2, 8'd20);

        chk("oe_dqm_outside_write", 64'(viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_ctrl_burst.md
Name: sdram_ctrl_burst

Overview:
Parametrised single-port SDRAM controller with per-bank open-page tracking, periodic auto-refresh, pipelined multi-beat read bursts and byte-masked writes. Timing, geometry and burst length are set by parameters. It sits between the user-project bus adapter (valid/ready request, valid-only response) and the SDRAM model pins, using split dq in/out.

Parameters:
DW, 32, data width in bits (multiple of 8)
COL_W, 8, column address bits
BANK_W, 2, bank address bits (NB = 2**BANK_W banks)
ROW_W, 13, row address bits; AW = ROW_W+BANK_W+COL_W
T_RCD, 3, ACTIVE-to-READ/WRITE cycles
T_RP, 3, PRECHARGE-to-next-command cycles
T_RFC, 7, REFRESH-to-next-command cycles
T_CAS, 3, READ command to data-valid on sdram_dqi, in cycles
T_REFI, 750, cycles between refresh requests
BURST, 4, read beats per read request (1..2**COL_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  controller accepts request this cycle
req_rw  in  1  1=write, 0=read
req_addr  in  AW  word address {row, bank, col}
req_wdata  in  DW  write data
req_be  in  DW/8  write byte enables
rsp_valid  out  1  one pulse per read beat
rsp_data  out  DW  read data
rsp_addr  out  AW  address of the returned beat
sdram_cke  out  1  clock enable
sdram_cs, sdram_ras, sdram_cas, sdram_we  out  1 each  command pins
sdram_ba  out  BANK_W  bank
sdram_a  out  ROW_W  address bus (A10 = all-banks on PRECHARGE)
sdram_dqm  out  DW/8  byte mask
sdram_dqi  in  DW  read data from SDRAM
sdram_dqo  out  DW  write data to SDRAM
sdram_dq_oe  out  1  write-data drive enable

Behaviour:
- Reset (rst) is synchronous and active-high; clock is clk.
- All pin outputs are registered. Commands are encoded as {cs,ras,cas,we}: NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001.
- During reset: cmd=NOP, cke=0, dq_oe=0, dqm=0, a=0, ba=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_addr=0.
- During reset, all banks are marked closed, the refresh counter is cleared and the refresh-pending flag is cleared.
- The power-up sequence is skipped. The cycle after reset releases, the controller enters IDLE with cke=1.
- req_ready = (state==IDLE) && !ref_pend && read pipeline empty. A request is accepted on req_valid && req_ready. The address, data, byte enables and rw are latched.
- States:
  - IDLE: if ref_pend and the pipeline is empty: go to PREALL. Else on an accepted request: if the bank is open with the same row, go to RD or WR; if the bank is open with another row, go to PRE; if the bank is closed, go to ACT.
  - PRE: issue PRE to one bank (A10=0), mark that bank closed, wait T_RP, then go to ACT.
  - PREALL: issue PRE with A10=1, mark all banks closed, wait T_RP, then go to REF.
  - ACT: issue ACT with the row and bank, record the open row, wait T_RCD, then go to RD or WR.
  - WR: issue WRITE with col. In the same cycle drive dqo=wdata, dq_oe=1, dqm=~be. Return to IDLE.
  - RD: issue READ for beats k=0..BURST-1 on consecutive cycles. The column is (col+k) mod 2**COL_W, wrapping within the row; bank and row are unchanged. Return to IDLE after the last beat.
  - REF: issue REF, clear ref_pend, wait T_RFC, then go to IDLE.
  - Waits: NOP is issued for the full count. A wait of N means the next command appears on the pins exactly N cycles after the previous one.
- Read pipeline:
  - A T_CAS-deep shift register carries a valid bit and the beat address.
  - sdram_dqi is sampled T_CAS cycles after READ appears on the pins.
  - rsp_valid, rsp_data and rsp_addr are registered and asserted on the next cycle. Read latency from READ on the pins to rsp_valid is T_CAS+1.
- Refresh:
  - The counter increments every cycle. On reaching T_REFI-1 it sets ref_pend and wraps to 0.
  - If ref_pend is already set, a further wrap does not queue a second refresh.
  - Refresh always has priority over a new request in IDLE.
  - A burst already in RD completes before refresh starts; the read pipeline drains first.
- A write never follows a read until the pipeline is empty, which is guaranteed by req_ready.
- dqm=0 on every cycle except WR.
- Reset mid-operation discards the pending request and all in-flight beats. No rsp_valid is produced after reset.

Test Plan:
- Read, closed bank: addr row=5, bank=1, col=8, BURST=4, defaults.
  -> ACT(ba=1, a=5); READ 3 cycles later for col 8, 9, 10, 11 on consecutive cycles.
  -> rsp_valid for 4 cycles starting 4 cycles after the first READ; rsp_addr increments by 1.
- Row hit then row conflict: read row 5 bank 1, then read row 5 bank 1 col 0, then read row 9 bank 1.
  -> The second read issues READ with no ACT.
  -> The third read issues PRE(ba=1, A10=0), then ACT row 9 after 3 cycles, then READ after another 3 cycles.
- Byte-masked write: req_be=4'b0101, wdata=32'hA5A5_1234.
  -> On the WRITE cycle: dq_oe=1, dqo=32'hA5A5_1234, dqm=4'b1010.
  -> The next cycle: dq_oe=0, dqm=0.
- Column wrap: read col=254 with BURST=4.
  -> READ columns 254, 255, 0, 1, all in the same row and bank.
- Refresh priority: hold req_valid when ref_pend is set.
  -> PRE with A10=1, then REF 3 cycles later, then req_ready rises 7 cycles after REF.
  -> The request is then serviced via ACT, because all banks are closed.
- Reset mid-burst: assert rst 1 cycle after the second READ.
  -> No rsp_valid afterwards; req_ready=1 one cycle after rst falls.
  -> The next read to the same row issues ACT first.
